// File: rtl/pwm_3phase_gen.sv
// Three-phase PWM commutation generator.
// A runtime step divider advances a six-step commutation index. The index
// selects a 120-degree-offset phase pattern, which is chopped by a free-running
// duty carrier. All outputs are registered.
module pwm_3phase_gen #(
  parameter int unsigned DIV_W  = 24,
  parameter int unsigned DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              dir,
  input  logic [DIV_W-1:0]  period,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_phase1,
  output logic              pwm_phase2,
  output logic              pwm_phase3,
  output logic [2:0]        step_idx,
  output logic              step_strobe,
  output logic              running
);

  logic              running_q,     running_d;
  logic [2:0]        step_idx_q,    step_idx_d;
  logic [DIV_W-1:0]  div_cnt_q,     div_cnt_d;
  logic [DIV_W-1:0]  period_q,      period_d;
  logic [DUTY_W-1:0] car_cnt_q,     car_cnt_d;
  logic              step_strobe_q, step_strobe_d;
  logic [2:0]        phase_q,       phase_d;

  logic [DIV_W-1:0]  period_min;
  logic [2:0]        step_next;
  logic [2:0]        pattern;
  logic              last_cnt;
  logic              chop;

  // Pattern, chop and next-step decode from current registered state
  always_comb begin
    period_min = (period < DIV_W'(2)) ? DIV_W'(2) : period;
    last_cnt   = (div_cnt_q == (period_q - DIV_W'(1)));
    chop       = (car_cnt_q < duty) | (&duty);

    if (dir) step_next = (step_idx_q == 3'd5) ? 3'd0 : step_idx_q + 3'd1;
    else     step_next = (step_idx_q == 3'd0) ? 3'd5 : step_idx_q - 3'd1;

    // Bit order {phase3, phase2, phase1}
    case (step_idx_q)
      3'd0:    pattern = 3'b101;
      3'd1:    pattern = 3'b001;
      3'd2:    pattern = 3'b011;
      3'd3:    pattern = 3'b010;
      3'd4:    pattern = 3'b110;
      3'd5:    pattern = 3'b100;
      default: pattern = 3'b000;
    endcase
  end

  // Next-state: enable low clears counters and outputs but holds step_idx;
  // a disable on an advance edge suppresses the advance.
  always_comb begin
    running_d     = enable;
    step_idx_d    = step_idx_q;
    div_cnt_d     = '0;
    car_cnt_d     = '0;
    period_d      = period_q;
    step_strobe_d = 1'b0;
    phase_d       = '0;

    if (enable) begin
      if (!running_q) begin
        period_d = period_min;
      end else begin
        car_cnt_d = car_cnt_q + DUTY_W'(1);
        phase_d   = pattern & {3{chop}};
        if (last_cnt) begin
          period_d      = period_min;
          step_idx_d    = step_next;
          step_strobe_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
    end
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q     <= 1'b0;
      step_idx_q    <= '0;
      div_cnt_q     <= '0;
      period_q      <= '0;
      car_cnt_q     <= '0;
      step_strobe_q <= 1'b0;
      phase_q       <= '0;
    end else begin
      running_q     <= running_d;
      step_idx_q    <= step_idx_d;
      div_cnt_q     <= div_cnt_d;
      period_q      <= period_d;
      car_cnt_q     <= car_cnt_d;
      step_strobe_q <= step_strobe_d;
      phase_q       <= phase_d;
    end
  end

  assign pwm_phase1  = phase_q[0];
  assign pwm_phase2  = phase_q[1];
  assign pwm_phase3  = phase_q[2];
  assign step_idx    = step_idx_q;
  assign step_strobe = step_strobe_q;
  assign running     = running_q;

endmodule

// File: tb/tb_pwm_3phase_gen.sv
// Directed bench for pwm_3phase_gen with a 4-bit duty carrier.
module tb_pwm_3phase_gen;

  localparam int unsigned DIV_W  = 24;
  localparam int unsigned DUTY_W = 4;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              dir;
  logic [DIV_W-1:0]  period;
  logic [DUTY_W-1:0] duty;
  logic              pwm_phase1;
  logic              pwm_phase2;
  logic              pwm_phase3;
  logic [2:0]        step_idx;
  logic              step_strobe;
  logic              running;

  int unsigned pass_cnt;
  int unsigned fail_cnt;
  int unsigned total_cnt;

  pwm_3phase_gen #(.DIV_W(DIV_W), .DUTY_W(DUTY_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .dir         (dir),
    .period      (period),
    .duty        (duty),
    .pwm_phase1  (pwm_phase1),
    .pwm_phase2  (pwm_phase2),
    .pwm_phase3  (pwm_phase3),
    .step_idx    (step_idx),
    .step_strobe (step_strobe),
    .running     (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {phase3, phase2, phase1} for a step index
  function automatic logic [2:0] pat(input int unsigned s);
    case (s)
      0:       pat = 3'b101;
      1:       pat = 3'b001;
      2:       pat = 3'b011;
      3:       pat = 3'b010;
      4:       pat = 3'b110;
      5:       pat = 3'b100;
      default: pat = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] phases();
    phases = {pwm_phase3, pwm_phase2, pwm_phase1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // quiet cycles with no strobe holding 'from', then one advance edge to 'to'
  task automatic expect_steps(input int unsigned quiet, input int unsigned from,
                              input int unsigned to, input string tag);
    for (int unsigned i = 0; i < quiet; i++) begin
      tick();
      chk({tag, "_hold_strobe"}, 32'(step_strobe), 32'd0);
      chk({tag, "_hold_step"}, 32'(step_idx), from);
    end
    tick();
    chk({tag, "_adv_strobe"}, 32'(step_strobe), 32'd1);
    chk({tag, "_adv_step"}, 32'(step_idx), to);
  endtask

  initial begin
    int unsigned h1, h2, h3, hc;
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;

    // Reset
    rst_n  = 1'b0;
    enable = 1'b0;
    dir    = 1'b1;
    period = 24'd4;
    duty   = 4'hF;
    tick();
    tick();
    chk("rst_phases",  32'(phases()),    32'd0);
    chk("rst_step",    32'(step_idx),    32'd0);
    chk("rst_strobe",  32'(step_strobe), 32'd0);
    chk("rst_running", 32'(running),     32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_running", 32'(running), 32'd0);

    // Forward, period 4, full duty
    enable = 1'b1;
    tick();  // E0
    chk("e0_running", 32'(running),  32'd1);
    chk("e0_phases",  32'(phases()), 32'd0);
    chk("e0_step",    32'(step_idx), 32'd0);
    h1 = 0; h2 = 0; h3 = 0;
    for (int unsigned k = 1; k <= 24; k++) begin
      tick();
      chk("fwd_step",   32'(step_idx),    (k / 4) % 6);
      chk("fwd_strobe", 32'(step_strobe), 32'((k % 4) == 0));
      chk("fwd_phases", 32'(phases()),    32'(pat(((k - 1) / 4) % 6)));
      h1 += 32'(pwm_phase1);
      h2 += 32'(pwm_phase2);
      h3 += 32'(pwm_phase3);
    end
    chk("fwd_p1_high", h1, 32'd12);
    chk("fwd_p2_high", h2, 32'd12);
    chk("fwd_p3_high", h3, 32'd12);

    // Reverse from step 0; dir flipped right before the k=28 advance edge
    for (int unsigned k = 25; k <= 48; k++) begin
      tick();
      if (k == 27) dir = 1'b0;
      chk("rev_step",   32'(step_idx),    (6 - ((k - 24) / 4) % 6) % 6);
      chk("rev_strobe", 32'(step_strobe), 32'((k % 4) == 0));
      chk("rev_phases", 32'(phases()),    32'(pat((6 - ((k - 25) / 4) % 6) % 6)));
    end

    // Period change mid-step: new value waits for the next advance
    period = 24'd10;
    dir    = 1'b1;
    expect_steps(3, 0, 1, "p4_to_p10");
    expect_steps(9, 1, 2, "p10_step");
    for (int unsigned i = 0; i < 5; i++) tick();
    chk("mid_step_strobe", 32'(step_strobe), 32'd0);
    period = 24'd3;
    expect_steps(4, 2, 3, "p10_tail");
    expect_steps(2, 3, 4, "p3_a");
    expect_steps(2, 4, 5, "p3_b");

    // Walk back to step 3, then disable exactly on an advance edge
    dir = 1'b0;
    expect_steps(2, 5, 4, "rev3_a");
    expect_steps(2, 4, 3, "rev3_b");
    tick();
    tick();
    chk("pre_dis_phases", 32'(phases()), 32'b010);
    enable = 1'b0;
    tick();
    chk("dis_step",    32'(step_idx),    32'd3);
    chk("dis_strobe",  32'(step_strobe), 32'd0);
    chk("dis_phases",  32'(phases()),    32'd0);
    chk("dis_running", 32'(running),     32'd0);
    period = 24'd5;
    hc = 0;
    for (int unsigned i = 0; i < 49; i++) begin
      tick();
      hc += 32'(step_strobe) + 32'(pwm_phase1) + 32'(pwm_phase2) + 32'(pwm_phase3);
    end
    chk("dis_quiet", hc, 32'd0);
    chk("dis_hold_step", 32'(step_idx), 32'd3);
    enable = 1'b1;
    tick();  // re-enable edge
    chk("reen_running", 32'(running), 32'd1);
    expect_steps(4, 3, 2, "reen");
    chk("reen_phases_old", 32'(phases()), 32'b010);
    tick();
    chk("reen_phases_new", 32'(phases()), 32'b011);

    // Chopping at duty 4, then 0, then all ones, on step 2
    enable = 1'b0;
    tick();
    period = 24'd1000;
    duty   = 4'd4;
    enable = 1'b1;
    tick();
    hc = 0;
    for (int unsigned j = 1; j <= 32; j++) begin
      tick();
      chk("duty4_p1", 32'(pwm_phase1), 32'(((j - 1) % 16) < 4));
      chk("duty4_p2", 32'(pwm_phase2), 32'(((j - 1) % 16) < 4));
      chk("duty4_p3", 32'(pwm_phase3), 32'd0);
      hc += 32'(pwm_phase1);
    end
    chk("duty4_high", hc, 32'd8);
    duty = 4'd0;
    hc = 0;
    for (int unsigned j = 0; j < 16; j++) begin
      tick();
      hc += 32'(pwm_phase1) + 32'(pwm_phase2) + 32'(pwm_phase3);
    end
    chk("duty0_high", hc, 32'd0);
    duty = 4'hF;
    hc = 0;
    for (int unsigned j = 0; j < 16; j++) begin
      tick();
      hc += 32'(pwm_phase1) + 32'(pwm_phase2);
      chk("duty15_p3", 32'(pwm_phase3), 32'd0);
    end
    chk("duty15_high", hc, 32'd32);
    chk("duty_step", 32'(step_idx), 32'd2);

    // Asynchronous reset mid-step while phases are high
    chk("pre_rst_phases", 32'(phases()), 32'b011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phases",  32'(phases()),    32'd0);
    chk("arst_step",    32'(step_idx),    32'd0);
    chk("arst_running", 32'(running),     32'd0);
    chk("arst_strobe",  32'(step_strobe), 32'd0);
    #2;
    rst_n  = 1'b1;
    period = 24'd0;
    dir    = 1'b1;
    enable = 1'b1;
    tick();  // E0
    chk("p0_running", 32'(running), 32'd1);
    expect_steps(1, 0, 1, "p0_a");
    expect_steps(1, 1, 2, "p0_b");

    // period 1 is also clamped to 2
    enable = 1'b0;
    period = 24'd1;
    tick();
    enable = 1'b1;
    tick();
    expect_steps(1, 2, 3, "p1_a");
    expect_steps(1, 3, 4, "p1_b");

    if (fail_cnt != 0) $display("%0d checks did not match", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_3phase_gen.md
# pwm_3phase_gen

Parametrised three-phase PWM commutation generator with an integrated step-rate divider, runtime step period, direction control and duty-cycle chopping. It replaces the fixed-rate pairing of a clock-tick divider and a 3-phase sequencer, and drives the motor-driver phase inputs directly from the 50 MHz system clock. Step period, direction and duty are runtime inputs, so the drive can be ramped and reversed without a rebuild.

## Interface
- DIV_W, 24: width of `period` and of the internal step divider.
- DUTY_W, 8: width of `duty`. The chopping carrier period is 2^DUTY_W clock cycles.

- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; when low, all phases are off and sequence state is held.
- dir  in  1  1 = forward (step_idx increments), 0 = reverse (step_idx decrements).
- period  in  DIV_W  clock cycles per commutation step; sampled only at latch points.
- duty  in  DUTY_W  chopping on-time in carrier counts; all-ones = continuous on.
- pwm_phase1, pwm_phase2, pwm_phase3  out  1 each  phase drive outputs, registered.
- step_idx  out  3  current commutation step, 0..5.
- step_strobe  out  1  one-cycle pulse on every step advance.
- running  out  1  registered copy of sampled enable.

## Operation
- State:
  - running
  - step_idx (0..5)
  - div_cnt (DIV_W)
  - period_q (DIV_W)
  - car_cnt (DUTY_W)
- Period latch:
  - period_q <= max(period, 2) on the edge where enable is first sampled high (running 0->1).
  - period_q is also reloaded on every step advance.
  - Changes to period mid-step have no effect until the next latch point.
- Divider, while running:
  - div_cnt counts 0..period_q-1, then wraps to 0.
  - At the wrap, step_idx advances and step_strobe = 1 for that cycle only.
- Step advance:
  - dir=1: step_idx = (step_idx+1) mod 6, so 5 -> 0.
  - dir=0: step_idx = (step_idx+5) mod 6, so 0 -> 5.
  - dir is sampled only at the advance edge.
- Phase pattern from step_idx:
  - phase1 on for {0,1,2}.
  - phase2 on for {2,3,4}.
  - phase3 on for {4,5,0}.
  - This gives three 50 % waveforms offset by 120° (two steps).
- Chopping:
  - car_cnt increments every cycle while running and wraps at 2^DUTY_W-1.
  - chop = (car_cnt < duty) | (duty == all ones).
  - duty = 0 gives all phases off.
- Output rule: pwm_phaseN <= running & pattern_N(step_idx) & chop.
- enable low, sampled:
  - running <= 0; outputs go 0 on the same edge.
  - div_cnt and car_cnt clear to 0.
  - step_idx is held, so motion resumes from the same electrical position.
  - step_strobe stays 0.
- enable re-asserted:
  - div_cnt = 0, car_cnt = 0, period_q relatched.
  - The first advance occurs period_q cycles later.

## Timing
- Reset (async, rst_n low): all outputs 0, step_idx = 0, running = 0, and all counters and period_q = 0.
  - Deassertion is synchronised by the existing reset tree.
  - The first enable sample occurs on the next clk edge.
- E0 is the edge where enable is first sampled high:
  - running = 1 after E0.
  - Outputs reflect step_idx 0 with chop from E0+1 onward (one register stage).
- Step advances at edges E0+P, E0+2P, … where P = period_q.
  - step_strobe is high for the cycle following each of those edges.
  - The new pattern appears on the outputs one edge later.
- Chop edges:
  - Phase goes on at car_cnt wrap (plus 1 cycle latency).
  - Phase goes off when car_cnt reaches duty.
- Reset mid-operation: everything returns to reset values immediately, with no glitch pulse on any phase.
- Boundaries:
  - period = 0 or 1 is treated as 2.
  - A simultaneous dir change and advance uses the new dir.
  - enable falling on an advance edge: enable wins, with no advance and no strobe.

## Test plan
- Reset, then enable=1, dir=1, period=4, duty=all ones:
  - step_idx steps 0,1,2,3,4,5,0 every 4 cycles.
  - step_strobe fires every 4th cycle.
  - phase1 is high for 12 of every 24 cycles; phase2 lags phase1 by 8 cycles and phase3 by 16.
- Same setup with dir=0 from step 0: step_idx sequence 0,5,4,3,2,1,0, with a strobe at each.
- period=10 running, then change period to 3 at cycle 5 of a step:
  - The current step still lasts 10 cycles.
  - Subsequent steps last 3 cycles.
- DUTY_W=4, duty=4, phase1 active: phase1 high 4 of every 16 cycles; duty=0 gives constantly low; duty=15 gives constantly high.
- Disable at step_idx=3 for 50 cycles, then re-enable:
  - All phases go 0 within 1 cycle and there is no strobe while disabled.
  - step_idx resumes at 3, and the first advance is P cycles after re-enable.
- Assert rst_n=0 asynchronously mid-step while phases are high: all outputs go 0 immediately; period=0 with enable then steps every 2 cycles.
